// File: rtl/mc8051_mem_if.sv
// mc8051_mem_if: serialises the S2/S3 read and S5 write requests of the mc8051 onto one memory bus.
// Latency: a zero-wait read takes 3 cycles from strobe to done, and each wait state adds one cycle.
// Backpressure: o_stall is high while any slot is pending or the bus is busy. A strobe to a pending slot is dropped.
// Ports:
//   i_clk, i_rst                      clock and asynchronous active-high reset
//   i_sN_req / i_sN_mem_addr_d / i_sN_space, i_mem_wdata
//                                     per-stage request strobes, address, space and write data
//   i_flush                           cancels S2/S3 reads that have not been granted yet
//   o_mem_*, i_mem_rdata, i_mem_ready bus address/space/wdata, rd/wr request and completion handshake
//   o_s2/s3_data_buffer, o_sN_done    read results and one-cycle completion pulses
//   o_stall, o_bus_err                busy indication and timeout pulse
module mc8051_mem_if #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_s2_req,
  input  logic        i_s3_req,
  input  logic        i_s5_req,
  input  logic [15:0] i_s2_mem_addr_d,
  input  logic [15:0] i_s3_mem_addr_d,
  input  logic [15:0] i_s5_mem_addr_d,
  input  logic [1:0]  i_s2_space,
  input  logic [1:0]  i_s3_space,
  input  logic [1:0]  i_s5_space,
  input  logic [7:0]  i_mem_wdata,
  input  logic        i_flush,
  output logic [15:0] o_mem_addr,
  output logic [1:0]  o_mem_space,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [7:0]  o_s2_data_buffer,
  output logic [7:0]  o_s3_data_buffer,
  output logic        o_s2_done,
  output logic        o_s3_done,
  output logic        o_s5_done,
  output logic        o_stall,
  output logic        o_bus_err
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic [1:0]        SLOT_S2  = 2'd0;
  localparam logic [1:0]        SLOT_S3  = 2'd1;
  localparam logic [1:0]        SLOT_S5  = 2'd2;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  state_e            state_q, state_d;
  logic              s2_pend_q, s2_pend_d, s3_pend_q, s3_pend_d, s5_pend_q, s5_pend_d;
  logic [15:0]       s2_addr_q, s2_addr_d, s3_addr_q, s3_addr_d, s5_addr_q, s5_addr_d;
  logic [1:0]        s2_space_q, s2_space_d, s3_space_q, s3_space_d, s5_space_q, s5_space_d;
  logic [7:0]        s5_wdata_q, s5_wdata_d;
  logic [1:0]        act_slot_q, act_slot_d;
  logic              act_flush_q, act_flush_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [15:0]       bus_addr_q, bus_addr_d;
  logic [1:0]        bus_space_q, bus_space_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;
  logic [7:0]        s2_buf_q, s2_buf_d, s3_buf_q, s3_buf_d;
  logic              s2_done_q, s2_done_d, s3_done_q, s3_done_d, s5_done_q, s5_done_d;
  logic              bus_err_q, bus_err_d;

  logic       is_access;
  logic       act_is_read;
  logic       read_kill;
  logic       finish;
  logic [7:0] rd_result;

  assign is_access   = (state_q == ST_ACCESS);
  assign act_is_read = (act_slot_q != SLOT_S5);
  // A read flushed while on the bus still finishes its bus cycle but is discarded.
  assign read_kill   = act_is_read & (act_flush_q | i_flush);
  // Completion on ready, or abort once the wait budget is spent.
  assign finish      = i_mem_ready | (wait_cnt_q == WAIT_LIM);
  assign rd_result   = i_mem_ready ? i_mem_rdata : 8'hFF;

  always_comb begin
    state_d     = state_q;
    s2_pend_d   = s2_pend_q;
    s3_pend_d   = s3_pend_q;
    s5_pend_d   = s5_pend_q;
    s2_addr_d   = s2_addr_q;
    s3_addr_d   = s3_addr_q;
    s5_addr_d   = s5_addr_q;
    s2_space_d  = s2_space_q;
    s3_space_d  = s3_space_q;
    s5_space_d  = s5_space_q;
    s5_wdata_d  = s5_wdata_q;
    act_slot_d  = act_slot_q;
    act_flush_d = act_flush_q;
    wait_cnt_d  = wait_cnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    bus_addr_d  = bus_addr_q;
    bus_space_d = bus_space_q;
    bus_wdata_d = bus_wdata_q;
    s2_buf_d    = s2_buf_q;
    s3_buf_d    = s3_buf_q;
    s2_done_d   = 1'b0;
    s3_done_d   = 1'b0;
    s5_done_d   = 1'b0;
    bus_err_d   = 1'b0;

    // Slot capture. A read strobe arriving together with a flush is dropped.
    if (i_s2_req && !s2_pend_q && !i_flush) begin
      s2_pend_d  = 1'b1;
      s2_addr_d  = i_s2_mem_addr_d;
      s2_space_d = i_s2_space;
    end
    if (i_s3_req && !s3_pend_q && !i_flush) begin
      s3_pend_d  = 1'b1;
      s3_addr_d  = i_s3_mem_addr_d;
      s3_space_d = i_s3_space;
    end
    if (i_s5_req && !s5_pend_q) begin
      s5_pend_d  = 1'b1;
      s5_addr_d  = i_s5_mem_addr_d;
      s5_space_d = i_s5_space;
      s5_wdata_d = i_mem_wdata;
    end

    // Flush drops reads that are not on the bus. The read on the bus keeps its
    // pending bit until it finishes, so a new strobe cannot reuse the slot early.
    if (i_flush) begin
      if (!(is_access && act_slot_q == SLOT_S2)) s2_pend_d = 1'b0;
      if (!(is_access && act_slot_q == SLOT_S3)) s3_pend_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Writes have priority, so an older write lands before a younger read.
        if (s5_pend_q || ((s2_pend_q || s3_pend_q) && !i_flush)) begin
          state_d     = ST_ACCESS;
          wait_cnt_d  = '0;
          act_flush_d = 1'b0;
          if (s5_pend_q) begin
            act_slot_d  = SLOT_S5;
            wr_d        = 1'b1;
            bus_addr_d  = s5_addr_q;
            bus_space_d = s5_space_q;
            bus_wdata_d = s5_wdata_q;
          end else if (s2_pend_q) begin
            act_slot_d  = SLOT_S2;
            rd_d        = 1'b1;
            bus_addr_d  = s2_addr_q;
            bus_space_d = s2_space_q;
          end else begin
            act_slot_d  = SLOT_S3;
            rd_d        = 1'b1;
            bus_addr_d  = s3_addr_q;
            bus_space_d = s3_space_q;
          end
        end
      end
      ST_ACCESS: begin
        if (finish) begin
          state_d   = ST_IDLE;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          bus_err_d = ~i_mem_ready;
          case (act_slot_q)
            SLOT_S2: begin
              s2_pend_d = 1'b0;
              if (!read_kill) begin
                s2_buf_d  = rd_result;
                s2_done_d = 1'b1;
              end
            end
            SLOT_S3: begin
              s3_pend_d = 1'b0;
              if (!read_kill) begin
                s3_buf_d  = rd_result;
                s3_done_d = 1'b1;
              end
            end
            default: begin
              s5_pend_d = 1'b0;
              s5_done_d = 1'b1;
            end
          endcase
        end else begin
          wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
          act_flush_d = read_kill;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      s2_pend_q   <= 1'b0;
      s3_pend_q   <= 1'b0;
      s5_pend_q   <= 1'b0;
      s2_addr_q   <= '0;
      s3_addr_q   <= '0;
      s5_addr_q   <= '0;
      s2_space_q  <= '0;
      s3_space_q  <= '0;
      s5_space_q  <= '0;
      s5_wdata_q  <= '0;
      act_slot_q  <= SLOT_S2;
      act_flush_q <= 1'b0;
      wait_cnt_q  <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      bus_addr_q  <= '0;
      bus_space_q <= '0;
      bus_wdata_q <= '0;
      s2_buf_q    <= 8'h00;
      s3_buf_q    <= 8'h00;
      s2_done_q   <= 1'b0;
      s3_done_q   <= 1'b0;
      s5_done_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s2_pend_q   <= s2_pend_d;
      s3_pend_q   <= s3_pend_d;
      s5_pend_q   <= s5_pend_d;
      s2_addr_q   <= s2_addr_d;
      s3_addr_q   <= s3_addr_d;
      s5_addr_q   <= s5_addr_d;
      s2_space_q  <= s2_space_d;
      s3_space_q  <= s3_space_d;
      s5_space_q  <= s5_space_d;
      s5_wdata_q  <= s5_wdata_d;
      act_slot_q  <= act_slot_d;
      act_flush_q <= act_flush_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_space_q <= bus_space_d;
      bus_wdata_q <= bus_wdata_d;
      s2_buf_q    <= s2_buf_d;
      s3_buf_q    <= s3_buf_d;
      s2_done_q   <= s2_done_d;
      s3_done_q   <= s3_done_d;
      s5_done_q   <= s5_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign o_mem_addr       = bus_addr_q;
  assign o_mem_space      = bus_space_q;
  assign o_mem_wdata      = bus_wdata_q;
  assign o_mem_rd         = rd_q;
  assign o_mem_wr         = wr_q;
  assign o_s2_data_buffer = s2_buf_q;
  assign o_s3_data_buffer = s3_buf_q;
  assign o_s2_done        = s2_done_q;
  assign o_s3_done        = s3_done_q;
  assign o_s5_done        = s5_done_q;
  assign o_bus_err        = bus_err_q;
  assign o_stall          = s2_pend_q | s3_pend_q | s5_pend_q | is_access |
                            i_s2_req | i_s3_req | i_s5_req;

endmodule

// File: tb/tb_mc8051_mem_if.sv
// Bench for mc8051_mem_if: directed scenarios plus a per-cycle reference model.
module tb_mc8051_mem_if;

  localparam int WAIT_MAX = 15;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_s2_req = 1'b0, i_s3_req = 1'b0, i_s5_req = 1'b0;
  logic [15:0] i_s2_mem_addr_d = '0, i_s3_mem_addr_d = '0, i_s5_mem_addr_d = '0;
  logic [1:0]  i_s2_space = '0, i_s3_space = '0, i_s5_space = '0;
  logic [7:0]  i_mem_wdata = '0;
  logic        i_flush = 1'b0;
  logic [15:0] o_mem_addr;
  logic [1:0]  o_mem_space;
  logic [7:0]  o_mem_wdata;
  logic        o_mem_rd, o_mem_wr;
  logic [7:0]  i_mem_rdata = 8'hEE;
  logic        i_mem_ready = 1'b0;
  logic [7:0]  o_s2_data_buffer, o_s3_data_buffer;
  logic        o_s2_done, o_s3_done, o_s5_done, o_stall, o_bus_err;

  mc8051_mem_if #(.WAIT_MAX(WAIT_MAX), .WAIT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_s2_req(i_s2_req), .i_s3_req(i_s3_req), .i_s5_req(i_s5_req),
    .i_s2_mem_addr_d(i_s2_mem_addr_d), .i_s3_mem_addr_d(i_s3_mem_addr_d),
    .i_s5_mem_addr_d(i_s5_mem_addr_d),
    .i_s2_space(i_s2_space), .i_s3_space(i_s3_space), .i_s5_space(i_s5_space),
    .i_mem_wdata(i_mem_wdata), .i_flush(i_flush),
    .o_mem_addr(o_mem_addr), .o_mem_space(o_mem_space), .o_mem_wdata(o_mem_wdata),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .o_s2_data_buffer(o_s2_data_buffer), .o_s3_data_buffer(o_s3_data_buffer),
    .o_s2_done(o_s2_done), .o_s3_done(o_s3_done), .o_s5_done(o_s5_done),
    .o_stall(o_stall), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Bus responder: ready arrives rdy_delay cycles after rd/wr rises.
  // Read data is addr[7:0]+0x70 on the ready cycle and garbage otherwise.
  typedef struct {
    bit          wr;
    logic [15:0] addr;
  } acc_t;
  acc_t log_q[$];
  int   rdy_delay = 0;
  int   bus_age = 0;

  always @(posedge i_clk) begin
    #1;
    if (o_mem_rd || o_mem_wr) begin
      if (bus_age == 0) log_q.push_back('{o_mem_wr, o_mem_addr});
      i_mem_ready = (bus_age == rdy_delay);
      i_mem_rdata = i_mem_ready ? o_mem_addr[7:0] + 8'h70 : 8'hEE;
      bus_age++;
    end else begin
      bus_age     = 0;
      i_mem_ready = 1'b0;
      i_mem_rdata = 8'hEE;
    end
  end

  // Reference model. Slot index: 0=S2, 1=S3, 2=S5.
  // m_act is the slot on the bus, or -1 when the bus is idle.
  bit          m_pend[3];
  logic [15:0] m_addr[3];
  logic [1:0]  m_space[3];
  logic [7:0]  m_wd;
  int          m_act = -1;
  int          m_wait = 0;
  bit          m_kill = 0;
  int          prio[3] = '{2, 0, 1};
  logic        e_rd = 0, e_wr = 0, e_err = 0;
  logic [15:0] e_addr = '0;
  logic [1:0]  e_space = '0;
  logic [7:0]  e_wdata = '0;
  logic [7:0]  e_buf[2];
  logic        e_done[3];

  always @(posedge i_clk or posedge i_rst) begin : mdl
    bit acc[3];
    bit killed;
    int cur;
    if (i_rst) begin
      for (int k = 0; k < 3; k++) begin
        m_pend[k] = 0; e_done[k] = 0;
      end
      e_buf[0] = 8'h00; e_buf[1] = 8'h00;
      m_act = -1; m_kill = 0; m_wait = 0;
      e_rd = 0; e_wr = 0; e_err = 0;
    end else begin
      acc[0] = i_s2_req && !m_pend[0] && !i_flush;
      acc[1] = i_s3_req && !m_pend[1] && !i_flush;
      acc[2] = i_s5_req && !m_pend[2];
      for (int k = 0; k < 3; k++) e_done[k] = 0;
      e_err = 0;
      cur = m_act;
      if (cur >= 0) begin
        killed = (cur != 2) && (m_kill || i_flush);
        if (i_mem_ready || m_wait == WAIT_MAX) begin
          if (!killed) begin
            if (cur != 2) e_buf[cur] = i_mem_ready ? i_mem_rdata : 8'hFF;
            e_done[cur] = 1;
          end
          e_err = !i_mem_ready;
          m_pend[cur] = 0;
          m_act = -1;
          e_rd = 0; e_wr = 0;
        end else begin
          m_wait++;
          m_kill = killed;
        end
        if (i_flush) begin
          for (int k = 0; k < 2; k++) if (k != cur) m_pend[k] = 0;
        end
      end else begin
        if (i_flush) begin
          m_pend[0] = 0; m_pend[1] = 0;
        end
        for (int i = 0; i < 3; i++) begin
          if (m_act < 0 && m_pend[prio[i]]) begin
            m_act = prio[i]; m_wait = 0; m_kill = 0;
            e_rd = (m_act != 2); e_wr = (m_act == 2);
            e_addr = m_addr[m_act]; e_space = m_space[m_act];
            if (m_act == 2) e_wdata = m_wd;
          end
        end
      end
      if (acc[0]) begin m_pend[0] = 1; m_addr[0] = i_s2_mem_addr_d; m_space[0] = i_s2_space; end
      if (acc[1]) begin m_pend[1] = 1; m_addr[1] = i_s3_mem_addr_d; m_space[1] = i_s3_space; end
      if (acc[2]) begin
        m_pend[2] = 1; m_addr[2] = i_s5_mem_addr_d; m_space[2] = i_s5_space; m_wd = i_mem_wdata;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("m_rd", o_mem_rd, e_rd);
      chk("m_wr", o_mem_wr, e_wr);
      if (e_rd || e_wr) begin
        chk("m_addr", o_mem_addr, e_addr);
        chk("m_space", o_mem_space, e_space);
      end
      if (e_wr) chk("m_wdata", o_mem_wdata, e_wdata);
      chk("m_s2_buf", o_s2_data_buffer, e_buf[0]);
      chk("m_s3_buf", o_s3_data_buffer, e_buf[1]);
      chk("m_s2_done", o_s2_done, e_done[0]);
      chk("m_s3_done", o_s3_done, e_done[1]);
      chk("m_s5_done", o_s5_done, e_done[2]);
      chk("m_bus_err", o_bus_err, e_err);
      chk("m_stall", o_stall, m_pend[0] | m_pend[1] | m_pend[2] | (m_act >= 0) |
                              i_s2_req | i_s3_req | i_s5_req);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_rd(string name);
    int n = 0;
    while (!o_mem_rd && n < 20) begin
      tick();
      n++;
    end
    chk(name, o_mem_rd, 1);
  endtask

  task automatic zero_wait_s2(string tag);
    rdy_delay = 0;
    tick();
    i_s2_req = 1; i_s2_mem_addr_d = 16'h0035; i_s2_space = 2'b00;
    tick();
    i_s2_req = 0;
    #2; chk({tag, "_c1_rd"}, o_mem_rd, 0);
    tick(); #2;
    chk({tag, "_c2_rd"}, o_mem_rd, 1);
    chk({tag, "_c2_addr"}, o_mem_addr, 16'h0035);
    tick(); #2;
    chk({tag, "_c3_rd"}, o_mem_rd, 0);
    chk({tag, "_c3_buf"}, o_s2_data_buffer, 8'hA5);
    chk({tag, "_c3_done"}, o_s2_done, 1);
    tick(); #2;
    chk({tag, "_c4_done"}, o_s2_done, 0);
    chk({tag, "_c4_buf"}, o_s2_data_buffer, 8'hA5);
  endtask

  initial begin
    int n, cnt, stall_low, s3d, s5d;
    logic [15:0] a0;
    bit addr_moved;

    // Reset state
    #2;
    chk("rst_rd", o_mem_rd, 0);
    chk("rst_wr", o_mem_wr, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_s2_buf", o_s2_data_buffer, 8'h00);
    chk("rst_done", {o_s2_done, o_s3_done, o_s5_done, o_bus_err}, 0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 0;
    tick();

    // 1: zero-wait S2 read
    zero_wait_s2("zw");
    tick();

    // 2: S2, S3 and S5 strobes in one cycle
    log_q.delete();
    rdy_delay = 0;
    i_s5_req = 1; i_s5_mem_addr_d = 16'h0040; i_s5_space = 2'b01; i_mem_wdata = 8'h3C;
    i_s2_req = 1; i_s2_mem_addr_d = 16'h0012; i_s2_space = 2'b00;
    i_s3_req = 1; i_s3_mem_addr_d = 16'h1234; i_s3_space = 2'b10;
    tick();
    i_s5_req = 0; i_s2_req = 0; i_s3_req = 0;
    n = 0; stall_low = 0;
    while (!o_s3_done && n < 40) begin
      if (!o_stall) stall_low++;
      tick();
      n++;
    end
    chk("ord_s3_done", o_s3_done, 1);
    chk("ord_latency", n, 6);
    chk("ord_stall_low", stall_low, 0);
    chk("ord_log_len", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("ord_0", {log_q[0].wr, log_q[0].addr}, {1'b1, 16'h0040});
      chk("ord_1", {log_q[1].wr, log_q[1].addr}, {1'b0, 16'h0012});
      chk("ord_2", {log_q[2].wr, log_q[2].addr}, {1'b0, 16'h1234});
    end
    chk("ord_s2_buf", o_s2_data_buffer, 8'h82);
    chk("ord_s3_buf", o_s3_data_buffer, 8'hA4);
    tick(); tick();

    // 3: S3 read with three wait states
    rdy_delay = 3;
    i_s3_req = 1; i_s3_mem_addr_d = 16'h00AB; i_s3_space = 2'b01;
    tick();
    i_s3_req = 0;
    wait_rd("ws_rd_start");
    cnt = 0; a0 = o_mem_addr; addr_moved = 0;
    while (o_mem_rd && cnt < 100) begin
      if (o_mem_addr !== a0) addr_moved = 1;
      cnt++;
      tick();
    end
    chk("ws_rd_cycles", cnt, 4);
    chk("ws_addr_stable", addr_moved, 0);
    #2;
    chk("ws_s3_buf", o_s3_data_buffer, 8'h1B);
    chk("ws_s3_done", o_s3_done, 1);
    tick(); tick();

    // 4: timeout with ready never asserted
    rdy_delay = 1000;
    i_s2_req = 1; i_s2_mem_addr_d = 16'h0100; i_s2_space = 2'b01;
    tick();
    i_s2_req = 0;
    wait_rd("to_rd_start");
    cnt = 0;
    while (o_mem_rd && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("to_rd_cycles", cnt, WAIT_MAX + 1);
    #2;
    chk("to_s2_buf", o_s2_data_buffer, 8'hFF);
    chk("to_done_err", {o_s2_done, o_bus_err}, 2'b11);
    tick(); #2;
    chk("to_err_pulse", {o_s2_done, o_bus_err}, 2'b00);
    tick();

    // 5: write on the bus, S3 pending, flush pulsed
    log_q.delete();
    rdy_delay = 2;
    i_s5_req = 1; i_s5_mem_addr_d = 16'h0050; i_s5_space = 2'b00; i_mem_wdata = 8'h77;
    i_s3_req = 1; i_s3_mem_addr_d = 16'h0060; i_s3_space = 2'b01;
    tick();
    i_s5_req = 0; i_s3_req = 0;
    tick();
    chk("fl_wr_active", o_mem_wr, 1);
    i_flush = 1;
    tick();
    i_flush = 0;
    s3d = 0; s5d = 0;
    repeat (30) begin
      if (o_s3_done) s3d++;
      if (o_s5_done) s5d++;
      tick();
    end
    chk("fl_s5_done", s5d, 1);
    chk("fl_s3_done", s3d, 0);
    chk("fl_log_len", log_q.size(), 1);
    if (log_q.size() == 1) chk("fl_log_0", {log_q[0].wr, log_q[0].addr}, {1'b1, 16'h0050});
    chk("fl_stall_end", o_stall, 0);

    // 6: reset during a wait-state read
    rdy_delay = 1000;
    i_s2_req = 1; i_s2_mem_addr_d = 16'h0035; i_s2_space = 2'b00;
    tick();
    i_s2_req = 0;
    wait_rd("rs_rd_start");
    tick(); tick();
    #2 i_rst = 1;
    #1;
    chk("rs_rd", o_mem_rd, 0);
    chk("rs_s2_buf", o_s2_data_buffer, 8'h00);
    chk("rs_s3_buf", o_s3_data_buffer, 8'h00);
    chk("rs_stall", o_stall, 0);
    tick(); #2;
    chk("rs_no_done", o_s2_done, 0);
    tick();
    i_rst = 0;
    zero_wait_s2("post");
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc8051_mem_if.md
# mc8051_mem_if

Memory access sequencer sitting directly downstream of the mc8051 operand/address mux. It captures the stage-2, stage-3 and stage-5 memory requests (address, space, write data) and serialises them onto the single core memory bus with a ready handshake. It returns read data as the S2/S3 data buffers consumed back by the mux and ALU, and raises a stall to the timing controller while work is outstanding.

## Interface
- WAIT_MAX, 15: maximum wait-state count before an access is aborted; range 1..255.
- WAIT_W, 8: wait counter width; must satisfy 2^WAIT_W > WAIT_MAX.

- i_clk  in  1  core clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_s2_req / i_s3_req  in  1  single-cycle read strobes for stage 2 and stage 3.
- i_s5_req  in  1  single-cycle write strobe for stage 5.
- i_s2_mem_addr_d / i_s3_mem_addr_d / i_s5_mem_addr_d  in  16  per-stage addresses from the mux.
- i_s2_space / i_s3_space / i_s5_space  in  2  address space: 00 IRAM/SFR, 01 XDATA, 10 CODE, 11 reserved. Passed through unchanged.
- i_mem_wdata  in  8  stage-5 write data from the mux.
- i_flush  in  1  cancels pending, not-yet-granted reads (branch taken).
- o_mem_addr  out  16  bus address.
- o_mem_space  out  2  bus space.
- o_mem_wdata  out  8  bus write data.
- o_mem_rd / o_mem_wr  out  1  bus read/write request, held until completion.
- i_mem_rdata  in  8  bus read data, sampled when i_mem_ready=1.
- i_mem_ready  in  1  bus completion.
- o_s2_data_buffer / o_s3_data_buffer  out  8  latched read results.
- o_s2_done / o_s3_done / o_s5_done  out  1  one-cycle completion pulses.
- o_stall  out  1  high while any slot is pending or an access is active.
- o_bus_err  out  1  one-cycle pulse on timeout abort.

## Operation
- There are three request slots (S2, S3, S5). Each holds addr, space, a pending bit, and wdata (S5 only). A strobe loads its slot and sets pending at the next edge.
- A strobe to a slot that is already pending is ignored, with no done pulse. The controller must honour o_stall.
- FSM states are IDLE and ACCESS.
- IDLE:
  - If any slot is pending, grant by priority S5 > S2 > S3. Writes go first so that an older instruction's write precedes a younger read.
  - Load the bus registers and go to ACCESS.
- ACCESS:
  - Drive o_mem_rd or o_mem_wr plus addr/space/wdata, all registered and stable for the whole access.
  - When i_mem_ready=1, the access completes:
    - read: buffer <= i_mem_rdata;
    - the done pulse and buffer update are visible in the next cycle;
    - clear the pending bit; return to IDLE.
- Wait counter:
  - Cleared on ACCESS entry; increments on each ACCESS cycle with i_mem_ready=0.
  - If counter==WAIT_MAX and i_mem_ready=0, abort: rd/wr drop, read buffer <= 8'hFF, done pulse plus o_bus_err pulse, pending cleared.
- Flush:
  - i_flush clears S2/S3 pending bits that have not been granted.
  - An active read runs to completion on the bus, but its buffer is not updated and no done pulse is issued.
  - S5 writes are never flushed.
  - A strobe and i_flush in the same cycle: the read strobe is dropped.
- o_stall = any pending | (state==ACCESS) | strobe this cycle (combinational on strobes).
- Reset values: all outputs 0, buffers 8'h00, state IDLE, all pending bits clear, counter 0.
- Reset asserted mid-access: o_mem_rd/o_mem_wr fall immediately and asynchronously; no done pulse follows.

## Timing
- Zero-wait read:
  - cycle 0: strobe;
  - cycle 1: pending, IDLE grants;
  - cycle 2: o_mem_rd=1 with ready;
  - cycle 3: buffer valid and done pulse.
  - Latency is 3 cycles.
- Every access costs 1 + (wait cycles) bus cycles plus one IDLE cycle before the next grant.
- A timed-out access holds rd/wr for exactly WAIT_MAX+1 cycles.
- The done and o_bus_err pulses last exactly one cycle. Buffers hold their value until overwritten.

## Test plan
- Zero-wait S2 read of 0x0035, space 00, ready tied high, rdata 0xA5:
  - o_mem_rd high only in cycle 2;
  - cycle 3: o_s2_data_buffer=0xA5 and o_s2_done=1.
- S2, S3 and S5 strobes in the same cycle (S5 addr 0x0040, wdata 0x3C):
  - bus order is write 0x0040, then S2 read, then S3 read, each separated by one idle cycle;
  - o_stall stays high until o_s3_done.
- S3 read where ready rises 3 cycles after o_mem_rd:
  - rd held 4 cycles with the address stable;
  - buffer = rdata captured in the ready cycle.
- WAIT_MAX=15, ready never asserted:
  - rd held 16 cycles;
  - then o_s2_data_buffer=0xFF, with o_s2_done and o_bus_err pulsed together.
- S5 write active with S3 read pending, i_flush pulsed:
  - the write completes;
  - the S3 read is never issued;
  - no o_s3_done.
- i_rst asserted during a wait-state read:
  - o_mem_rd=0 in the same cycle, buffers 0x00, o_stall=0;
  - after release, a new S2 request behaves as in the first scenario.
